// File: rtl/cache_write_buffer.sv
// Byte-masked store buffer feeding the cache way array.
// Ports: req_* store in, way_* write out, lk_* probe, flush/drained, err_way, count.
module cache_write_buffer #(
  parameter int NUM_WAYS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_W    = 6,
  parameter int OFFSET_W   = 2,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [NUM_WAYS-1:0]         req_way,
  input  logic [INDEX_W-1:0]          req_index,
  input  logic [OFFSET_W-1:0]         req_offset,
  input  logic [DATA_WIDTH-1:0]       req_data,
  input  logic [DATA_WIDTH/8-1:0]     req_be,
  output logic [NUM_WAYS-1:0]         way_wEn,
  output logic [INDEX_W-1:0]          way_index,
  output logic [OFFSET_W-1:0]         way_offset,
  output logic [DATA_WIDTH-1:0]       way_dataIn,
  output logic [DATA_WIDTH/8-1:0]     way_be,
  input  logic [NUM_WAYS-1:0]         way_ready,
  input  logic [INDEX_W-1:0]          lk_index,
  output logic                        lk_hit,
  input  logic                        flush,
  output logic                        drained,
  output logic                        err_way,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [NUM_WAYS-1:0]   way;
    logic [INDEX_W-1:0]    index;
    logic [OFFSET_W-1:0]   offset;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_W-1:0]       be;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               err_q;
  state_t             state;
  state_t             state_nxt;

  logic               full;
  logic               empty;
  logic               onehot;
  logic               accept;
  logic               push;
  logic               pop;
  logic [DATA_WIDTH-1:0] masked;
  entry_t             head;

  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);
  assign onehot = (req_way != '0) &&
                  ((req_way & (req_way - 1'b1)) == '0);

  // Acceptance looks at occupancy, state and flush only, never way_ready.
  assign req_ready = !full && (state != FLUSH) && !flush;
  assign accept    = req_valid && req_ready;
  // Zero-byte stores are swallowed: accepted but never queued.
  assign push      = accept && onehot && (|req_be);

  always_comb begin
    masked = '0;
    for (int b = 0; b < BE_W; b++) begin
      if (req_be[b]) masked[8*b +: 8] = req_data[8*b +: 8];
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    way_wEn    = '0;
    way_index  = '0;
    way_offset = '0;
    way_dataIn = '0;
    way_be     = '0;
    if (!empty) begin
      way_wEn    = head.way;
      way_index  = head.index;
      way_offset = head.offset;
      way_dataIn = head.data;
      way_be     = head.be;
    end
  end

  assign pop = !empty && (|(way_wEn & way_ready));

  always_comb begin
    lk_hit = push && (req_index == lk_index);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (mem[i].index == lk_index)) lk_hit = 1'b1;
    end
  end

  // Storage carries no reset; vld and cnt qualify every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{
        way:    req_way,
        index:  req_index,
        offset: req_offset,
        data:   masked,
        be:     req_be
      };
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
      state  <= IDLE;
    end else begin
      state <= state_nxt;
      err_q <= accept && !onehot;
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (flush)     state_nxt = FLUSH;
        else if (push) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (flush)
          state_nxt = FLUSH;
        else if (pop && !push && (cnt == CNT_W'(1)))
          state_nxt = IDLE;
      end
      FLUSH: begin
        if (empty && !flush) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign drained = empty && (state != DRAIN);
  assign err_way = err_q;
  assign count   = cnt;

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed bench for cache_write_buffer.
// Retired writes are checked against a queue filled at drive time.
module tb_cache_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_way;
  logic [5:0]  req_index;
  logic [1:0]  req_offset;
  logic [31:0] req_data;
  logic [3:0]  req_be;
  logic [3:0]  way_wEn;
  logic [5:0]  way_index;
  logic [1:0]  way_offset;
  logic [31:0] way_dataIn;
  logic [3:0]  way_be;
  logic [3:0]  way_ready;
  logic [5:0]  lk_index;
  logic        lk_hit;
  logic        flush;
  logic        drained;
  logic        err_way;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [47:0] sb [$];

  always #5 clk = ~clk;

  cache_write_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_way    (req_way),
    .req_index  (req_index),
    .req_offset (req_offset),
    .req_data   (req_data),
    .req_be     (req_be),
    .way_wEn    (way_wEn),
    .way_index  (way_index),
    .way_offset (way_offset),
    .way_dataIn (way_dataIn),
    .way_be     (way_be),
    .way_ready  (way_ready),
    .lk_index   (lk_index),
    .lk_hit     (lk_hit),
    .flush      (flush),
    .drained    (drained),
    .err_way    (err_way),
    .count      (count)
  );

  task automatic chk(input string tag,
                     input logic [47:0] obs,
                     input logic [47:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] msk(input logic [31:0] d,
                                      input logic [3:0] be);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic drive(input logic [3:0] w, input logic [5:0] idx,
                       input logic [1:0] off, input logic [31:0] d,
                       input logic [3:0] be);
    req_valid  = 1'b1;
    req_way    = w;
    req_index  = idx;
    req_offset = off;
    req_data   = d;
    req_be     = be;
  endtask

  task automatic expect_wr(input logic [3:0] w, input logic [5:0] idx,
                           input logic [1:0] off, input logic [31:0] d,
                           input logic [3:0] be);
    sb.push_back({w, idx, off, msk(d, be), be});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // A write retires on the coming edge; compare it with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ((way_wEn & way_ready) != 4'b0)) begin
      if (sb.size() == 0) begin
        chk("retire_unexpected",
            {way_wEn, way_index, way_offset, way_dataIn, way_be}, 48'h0);
      end else begin
        chk("retire_order",
            {way_wEn, way_index, way_offset, way_dataIn, way_be},
            sb.pop_front());
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_way    = '0;
    req_index  = '0;
    req_offset = '0;
    req_data   = '0;
    req_be     = '0;
    way_ready  = 4'hF;
    lk_index   = '0;
    flush      = 1'b0;
    #1;
    chk("rst_count", 48'(count), 48'd0);
    chk("rst_wen", 48'(way_wEn), 48'd0);
    chk("rst_data", 48'(way_dataIn), 48'd0);
    chk("rst_be", 48'(way_be), 48'd0);
    chk("rst_idx_off", 48'({way_index, way_offset}), 48'd0);
    chk("rst_err", 48'(err_way), 48'd0);
    chk("rst_drained", 48'(drained), 48'd1);
    chk("rst_ready", 48'(req_ready), 48'd1);
    tick;
    rst_n = 1'b1;
    tick;

    // Single write
    drive(4'b0100, 6'd5, 2'd1, 32'hDEADBEEF, 4'hF);
    expect_wr(4'b0100, 6'd5, 2'd1, 32'hDEADBEEF, 4'hF);
    lk_index = 6'd5;
    #1;
    chk("lk_same_cycle", 48'(lk_hit), 48'd1);
    tick;
    req_valid = 1'b0;
    #1;
    chk("single_wen", 48'(way_wEn), 48'h4);
    chk("single_data", 48'(way_dataIn), 48'hDEADBEEF);
    chk("single_idx_off", 48'({way_index, way_offset}), 48'({6'd5, 2'd1}));
    chk("single_count1", 48'(count), 48'd1);
    chk("lk_hit_pending", 48'(lk_hit), 48'd1);
    lk_index = 6'd6;
    #1;
    chk("lk_miss", 48'(lk_hit), 48'd0);
    tick;
    chk("single_count0", 48'(count), 48'd0);
    chk("single_drained", 48'(drained), 48'd1);

    // Byte mask
    drive(4'b0001, 6'd7, 2'd2, 32'hAABBCCDD, 4'b0101);
    expect_wr(4'b0001, 6'd7, 2'd2, 32'hAABBCCDD, 4'b0101);
    tick;
    req_valid = 1'b0;
    chk("mask_data", 48'(way_dataIn), 48'h00BB00DD);
    chk("mask_be", 48'(way_be), 48'h5);
    tick;

    // Backpressure to full
    way_ready = 4'h0;
    for (int k = 0; k < 4; k++) begin
      drive(4'(1 << k), 6'(10 + k), 2'(k), 32'h1000_0000 + k, 4'hF);
      expect_wr(4'(1 << k), 6'(10 + k), 2'(k), 32'h1000_0000 + k, 4'hF);
      tick;
    end
    chk("full_count", 48'(count), 48'd4);
    chk("full_ready", 48'(req_ready), 48'd0);
    chk("full_head", 48'(way_wEn), 48'h1);
    drive(4'b0010, 6'd20, 2'd3, 32'h0000_0055, 4'hF);
    tick;
    chk("held_count", 48'(count), 48'd4);
    tick;
    chk("held_ready", 48'(req_ready), 48'd0);
    way_ready = 4'hF;
    expect_wr(4'b0010, 6'd20, 2'd3, 32'h0000_0055, 4'hF);
    tick;
    chk("release_count", 48'(count), 48'd3);
    chk("release_ready", 48'(req_ready), 48'd1);
    tick;
    chk("pushpop_count", 48'(count), 48'd3);

    // Push and pop together across pointer wrap
    for (int k = 0; k < 4; k++) begin
      drive(4'(8 >> k), 6'(30 + k), 2'(k), 32'hC0DE_0000 + k, 4'(15 - k));
      expect_wr(4'(8 >> k), 6'(30 + k), 2'(k), 32'hC0DE_0000 + k, 4'(15 - k));
      tick;
      chk("wrap_count", 48'(count), 48'd3);
    end
    req_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("wrap_empty", 48'(count), 48'd0);
    chk("wrap_sb_empty", 48'(sb.size()), 48'd0);

    // Illegal way and zero byte-enable
    drive(4'b0110, 6'd1, 2'd0, 32'h1234_5678, 4'hF);
    tick;
    req_valid = 1'b0;
    chk("illegal_err", 48'(err_way), 48'd1);
    chk("illegal_count", 48'(count), 48'd0);
    tick;
    chk("illegal_err_clear", 48'(err_way), 48'd0);
    drive(4'b0000, 6'd1, 2'd0, 32'h1234_5678, 4'hF);
    tick;
    req_valid = 1'b0;
    chk("zero_way_err", 48'(err_way), 48'd1);
    drive(4'b0001, 6'd1, 2'd0, 32'h1234_5678, 4'h0);
    tick;
    req_valid = 1'b0;
    chk("be0_count", 48'(count), 48'd0);
    chk("be0_err", 48'(err_way), 48'd0);

    // Flush with three pending
    way_ready = 4'h0;
    for (int k = 0; k < 3; k++) begin
      drive(4'b0010, 6'(40 + k), 2'(k), 32'hF00D_0000 + k, 4'hF);
      expect_wr(4'b0010, 6'(40 + k), 2'(k), 32'hF00D_0000 + k, 4'hF);
      tick;
    end
    req_valid = 1'b0;
    flush = 1'b1;
    tick;
    chk("flush_ready", 48'(req_ready), 48'd0);
    chk("flush_count", 48'(count), 48'd3);
    chk("flush_not_drained", 48'(drained), 48'd0);
    way_ready = 4'hF;
    drive(4'b0001, 6'd50, 2'd0, 32'hBAD0_BAD0, 4'hF);
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk("flush_count0", 48'(count), 48'd0);
    chk("flush_drained", 48'(drained), 48'd1);
    chk("flush_hold_ready", 48'(req_ready), 48'd0);
    flush = 1'b0;
    tick;
    chk("flush_exit_ready", 48'(req_ready), 48'd1);

    // Reset mid-drain
    way_ready = 4'h0;
    for (int k = 0; k < 2; k++) begin
      drive(4'b1000, 6'(60 + k), 2'(k), 32'hABCD_0000 + k, 4'hF);
      expect_wr(4'b1000, 6'(60 + k), 2'(k), 32'hABCD_0000 + k, 4'hF);
      tick;
    end
    req_valid = 1'b0;
    way_ready = 4'hF;
    tick;
    chk("middrain_count", 48'(count), 48'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_wen", 48'(way_wEn), 48'd0);
    chk("async_rst_count", 48'(count), 48'd0);
    chk("async_rst_drained", 48'(drained), 48'd1);
    sb.delete();
    tick;
    rst_n = 1'b1;
    tick;
    chk("final_sb_empty", 48'(sb.size()), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
